// File: rtl/prog_mem_if.sv
// Host-load and core-fetch handshake bundle for prog_mem_responder.
// master = host/core side, slave = responder side.
interface prog_mem_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       reload;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ready;
    logic       fetch_valid;
    logic [7:0] instruction;
    logic       fault;

    modport master (
        output load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
        input  load_ready, fetch_ready, fetch_valid, instruction, fault
    );

    modport slave (
        input  load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
        output load_ready, fetch_ready, fetch_valid, instruction, fault
    );
endinterface

// File: rtl/prog_mem_responder.sv
// Program-image store for the 8-bit core: byte-wise host load, then fixed-latency
// instruction fetch with out-of-range fetches answered by NOP plus a fault flag.
module prog_mem_responder #(
    parameter int unsigned AW      = 5,
    parameter int unsigned LATENCY = 1,
    parameter logic [7:0]  NOP     = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    prog_mem_if.slave     bus,
    output logic [AW:0]   o_prog_len,
    output logic [1:0]    o_state
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_LOAD  = 2'b01,
        ST_READY = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_prog_len;
    logic          r_busy;
    logic [1:0]    r_cnt;
    logic [7:0]    r_addr;
    logic          r_valid;
    logic          r_fault;
    logic [7:0]    r_instr;

    logic          w_load_ready;
    logic          w_fetch_ready;
    logic          w_load_acc;
    logic          w_fetch_acc;
    logic          w_fire;
    logic          w_in_range;
    logic [7:0]    w_src_addr;

    // NOTE: every clocked process uses <= so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next_state;
    end

    // NOTE: defaulting every always_comb output first keeps unlisted paths from inferring latches.
    always_comb begin
        w_next_state = r_state;
        if (bus.reload)
            w_next_state = ST_EMPTY;
        else if (w_load_acc)
            w_next_state = (bus.load_last || (&r_wr_ptr)) ? ST_READY : ST_LOAD;
    end

    // Reload wins over any same-cycle byte or fetch, so both readies drop with it.
    always_comb begin
        w_load_ready  = 1'b0;
        w_fetch_ready = 1'b0;
        case (r_state)
            ST_EMPTY, ST_LOAD: w_load_ready  = !bus.reload;
            ST_READY:          w_fetch_ready = !bus.reload && !r_busy;
            default:           ;
        endcase
    end

    assign w_load_acc  = bus.load_valid && w_load_ready;
    assign w_fetch_acc = bus.fetch_req  && w_fetch_ready;

    // Latency 1 answers straight off the accepting edge; longer latencies count down.
    assign w_fire      = (LATENCY == 1) ? w_fetch_acc : (r_busy && (r_cnt == 2'd1));
    assign w_src_addr  = (LATENCY == 1) ? bus.fetch_addr : r_addr;
    assign w_in_range  = w_src_addr < 8'(r_prog_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
        end else if (bus.reload) begin
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
        end else if (w_load_acc) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_prog_len <= r_prog_len + (AW + 1)'(1);
        end
    end

    // NOTE: the array is left unreset; prog_len gates every read so stale bytes never escape.
    always_ff @(posedge clk) begin
        if (w_load_acc)
            r_mem[r_wr_ptr] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_instr <= NOP;
        end else begin
            r_valid <= w_fire && !bus.reload;
            r_fault <= w_fire && !bus.reload && !w_in_range;
            if (w_fire && !bus.reload)
                r_instr <= w_in_range ? r_mem[w_src_addr[AW-1:0]] : NOP;

            if (bus.reload) begin
                r_busy <= 1'b0;
            end else if (w_fetch_acc && (LATENCY > 1)) begin
                r_busy <= 1'b1;
                r_cnt  <= 2'(LATENCY - 1);
                r_addr <= bus.fetch_addr;
            end else if (r_busy) begin
                if (r_cnt == 2'd1)
                    r_busy <= 1'b0;
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign bus.load_ready  = w_load_ready;
    assign bus.fetch_ready = w_fetch_ready;
    assign bus.fetch_valid = r_valid;
    assign bus.instruction = r_instr;
    assign bus.fault       = r_fault;
    assign o_prog_len      = r_prog_len;
    assign o_state         = r_state;
endmodule
